hpdcache_rsp_demux: RTL and testbench

HPDCACHE_RSP_DEMUX -- requirements
Module: hpdcache_rsp_demux

---
 rtl/hpdcache_rsp_demux.sv | 117 +++++++++++
 tb/tb_hpdcache_rsp_demux.sv | 263 ++++++++++++++++++++++++++
 2 files changed

// File: rtl/hpdcache_rsp_demux.sv
// Response demultiplexer: one upstream response stream fans out to N per-destination FIFOs.
// Responses carrying an out-of-range destination ID are dropped and counted.
module hpdcache_rsp_demux #(
  parameter int unsigned N      = 4,
  parameter int unsigned DATA_W = 64,
  parameter int unsigned DEPTH  = 2,
  parameter int unsigned ID_W   = 2
) (
  input  logic                       clk_i,
  input  logic                       rst_ni,
  input  logic                       rsp_valid_i,
  output logic                       rsp_ready_o,
  input  logic [ID_W-1:0]            rsp_id_i,
  input  logic [DATA_W-1:0]          rsp_data_i,
  output logic [N-1:0]               rsp_valid_o,
  input  logic [N-1:0]               rsp_ready_i,
  output logic [N-1:0][DATA_W-1:0]   rsp_data_o,
  output logic                       err_o,
  output logic [7:0]                 err_cnt_o
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = $clog2(DEPTH + 1);

  logic [PTR_W-1:0]  rd_ptr_q [N];
  logic [PTR_W-1:0]  rd_ptr_d [N];
  logic [PTR_W-1:0]  wr_ptr_q [N];
  logic [PTR_W-1:0]  wr_ptr_d [N];
  logic [CNT_W-1:0]  cnt_q    [N];
  logic [CNT_W-1:0]  cnt_d    [N];
  logic [DATA_W-1:0] mem_q    [N][DEPTH];
  logic [DATA_W-1:0] mem_d    [N][DEPTH];

  logic [N-1:0] full;
  logic [N-1:0] push;
  logic [N-1:0] pop;
  logic         id_oob;
  logic         drop;
  logic         err_q;
  logic         err_d;
  logic [7:0]   err_cnt_q;
  logic [7:0]   err_cnt_d;

  assign id_oob = 32'(rsp_id_i) >= N;
  assign drop   = rsp_valid_i && id_oob;

  // Upstream ready only looks at registered occupancy, never at downstream ready.
  always_comb begin
    rsp_ready_o = 1'b1;
    for (int unsigned k = 0; k < N; k++) begin
      full[k]        = (cnt_q[k] == CNT_W'(DEPTH));
      rsp_valid_o[k] = (cnt_q[k] != '0);
      rsp_data_o[k]  = mem_q[k][rd_ptr_q[k]];
      pop[k]         = (cnt_q[k] != '0) && rsp_ready_i[k];
      push[k]        = rsp_valid_i && !full[k] && (32'(rsp_id_i) == k);
      if (32'(rsp_id_i) == k) begin
        rsp_ready_o = !full[k];
      end
    end
  end

  always_comb begin
    mem_d = mem_q;
    for (int unsigned k = 0; k < N; k++) begin
      rd_ptr_d[k] = rd_ptr_q[k];
      wr_ptr_d[k] = wr_ptr_q[k];
      cnt_d[k]    = cnt_q[k];
      if (push[k]) begin
        mem_d[k][wr_ptr_q[k]] = rsp_data_i;
        wr_ptr_d[k]           = wr_ptr_q[k] + 1'b1;
      end
      if (pop[k]) begin
        rd_ptr_d[k] = rd_ptr_q[k] + 1'b1;
      end
      case ({push[k], pop[k]})
        2'b10:   cnt_d[k] = cnt_q[k] + 1'b1;
        2'b01:   cnt_d[k] = cnt_q[k] - 1'b1;
        default: cnt_d[k] = cnt_q[k];
      endcase
    end
  end

  always_comb begin
    err_d     = err_q | drop;
    err_cnt_d = err_cnt_q;
    if (drop && (err_cnt_q != 8'hFF)) begin
      err_cnt_d = err_cnt_q + 8'd1;
    end
  end

  always_ff @(posedge clk_i or negedge rst_ni) begin
    if (!rst_ni) begin
      for (int unsigned k = 0; k < N; k++) begin
        rd_ptr_q[k] <= '0;
        wr_ptr_q[k] <= '0;
        cnt_q[k]    <= '0;
      end
      err_q     <= 1'b0;
      err_cnt_q <= 8'd0;
    end else begin
      rd_ptr_q  <= rd_ptr_d;
      wr_ptr_q  <= wr_ptr_d;
      cnt_q     <= cnt_d;
      err_q     <= err_d;
      err_cnt_q <= err_cnt_d;
    end
  end

  // Payload storage is not reset; occupancy alone decides what is valid.
  always_ff @(posedge clk_i) begin
    mem_q <= mem_d;
  end

  assign err_o     = err_q;
  assign err_cnt_o = err_cnt_q;

endmodule

// File: tb/tb_hpdcache_rsp_demux.sv
// Directed and random checks of hpdcache_rsp_demux: a 4-destination instance for routing,
// ordering and reset, plus a 3-destination instance for out-of-range drop counting.
module tb_hpdcache_rsp_demux;

  localparam int N     = 4;
  localparam int DW    = 64;
  localparam int DEPTH = 2;
  localparam int N3    = 3;
  localparam int DW3   = 8;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic                  v;
  logic                  ro;
  logic [1:0]            id;
  logic [DW-1:0]         d;
  logic [N-1:0]          vo;
  logic [N-1:0]          ri;
  logic [N-1:0][DW-1:0]  dout;
  logic                  err;
  logic [7:0]            err_cnt;

  logic                  v3;
  logic                  ro3;
  logic [1:0]            id3;
  logic [DW3-1:0]        d3;
  logic [N3-1:0]         vo3;
  logic [N3-1:0]         ri3;
  logic [N3-1:0][DW3-1:0] dout3;
  logic                  err3;
  logic [7:0]            err_cnt3;

  hpdcache_rsp_demux #(.N(N), .DATA_W(DW), .DEPTH(DEPTH), .ID_W(2)) dut (
    .clk_i(clk), .rst_ni(rst_n),
    .rsp_valid_i(v), .rsp_ready_o(ro), .rsp_id_i(id), .rsp_data_i(d),
    .rsp_valid_o(vo), .rsp_ready_i(ri), .rsp_data_o(dout),
    .err_o(err), .err_cnt_o(err_cnt)
  );

  hpdcache_rsp_demux #(.N(N3), .DATA_W(DW3), .DEPTH(DEPTH), .ID_W(2)) dut3 (
    .clk_i(clk), .rst_ni(rst_n),
    .rsp_valid_i(v3), .rsp_ready_o(ro3), .rsp_id_i(id3), .rsp_data_i(d3),
    .rsp_valid_o(vo3), .rsp_ready_i(ri3), .rsp_data_o(dout3),
    .err_o(err3), .err_cnt_o(err_cnt3)
  );

  typedef struct packed {
    logic          v;
    logic [1:0]    id;
    logic [63:0]   d;
    logic [3:0]    rdy;
    logic          exp_ro;
    logic [3:0]    exp_vo;
    logic          chk_d;
    logic [1:0]    chk_id;
    logic [63:0]   exp_d;
  } vec_t;

  vec_t vecs [9];
  int n_cmp = 0;
  int n_bad = 0;
  logic [63:0] model_q [N][$];

  task automatic checkOutput(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic applyStimulus(input logic vv, input logic [1:0] ii, input logic [63:0] dd,
                               input logic [3:0] rr);
    v  = vv;
    id = ii;
    d  = dd;
    ri = rr;
    #1;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic doReset();
    rst_n = 1'b0;
    v = 1'b0; id = '0; d = '0; ri = '0;
    v3 = 1'b0; id3 = '0; d3 = '0; ri3 = '0;
    tick();
    tick();
    rst_n = 1'b1;
  endtask

  // One cycle of random traffic against the queue model; ready/valid/data checked before the edge.
  task automatic randomStep(input logic vv, input logic [1:0] ii, input logic [63:0] dd,
                            input logic [3:0] rr);
    logic exp_ro;
    applyStimulus(vv, ii, dd, rr);
    exp_ro = (model_q[ii].size() < DEPTH);
    checkOutput("rand ready_o", 64'(ro), 64'(exp_ro));
    for (int k = 0; k < N; k++) begin
      checkOutput($sformatf("rand valid_o[%0d]", k), 64'(vo[k]), 64'(model_q[k].size() != 0));
      if (model_q[k].size() != 0) begin
        checkOutput($sformatf("rand data_o[%0d]", k), dout[k], model_q[k][0]);
      end
    end
    for (int k = 0; k < N; k++) begin
      if (model_q[k].size() != 0 && rr[k]) void'(model_q[k].pop_front());
    end
    if (vv && exp_ro) model_q[ii].push_back(dd);
    tick();
  endtask

  initial begin
    vecs[0] = '{1'b1, 2'd2, 64'hA5, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 64'hA5};
    vecs[1] = '{1'b0, 2'd2, 64'hFF, 4'b0000, 1'b1, 4'b0100, 1'b1, 2'd2, 64'hA5};
    vecs[2] = '{1'b1, 2'd0, 64'h11, 4'b0000, 1'b1, 4'b0101, 1'b1, 2'd0, 64'h11};
    vecs[3] = '{1'b1, 2'd0, 64'h22, 4'b0000, 1'b1, 4'b0101, 1'b1, 2'd0, 64'h11};
    vecs[4] = '{1'b1, 2'd0, 64'h33, 4'b0001, 1'b0, 4'b0101, 1'b1, 2'd0, 64'h22};
    vecs[5] = '{1'b1, 2'd0, 64'h33, 4'b0000, 1'b1, 4'b0101, 1'b1, 2'd0, 64'h22};
    vecs[6] = '{1'b1, 2'd3, 64'h44, 4'b0101, 1'b1, 4'b1001, 1'b1, 2'd3, 64'h44};
    vecs[7] = '{1'b1, 2'd0, 64'h55, 4'b0001, 1'b1, 4'b1001, 1'b1, 2'd0, 64'h55};
    vecs[8] = '{1'b0, 2'd0, 64'h00, 4'b1001, 1'b1, 4'b0000, 1'b0, 2'd0, 64'h00};

    doReset();
    checkOutput("reset valid_o", 64'(vo), 64'h0);
    checkOutput("reset err_o", 64'(err), 64'h0);
    checkOutput("reset err_cnt_o", 64'(err_cnt), 64'h0);
    checkOutput("reset dut3 valid_o", 64'(vo3), 64'h0);
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 2'(i), 64'h0, 4'b0000);
      checkOutput($sformatf("reset ready_o id%0d", i), 64'(ro), 64'h1);
    end

    for (int i = 0; i < 9; i++) begin
      applyStimulus(vecs[i].v, vecs[i].id, vecs[i].d, vecs[i].rdy);
      checkOutput($sformatf("vec%0d ready_o", i), 64'(ro), 64'(vecs[i].exp_ro));
      tick();
      checkOutput($sformatf("vec%0d valid_o", i), 64'(vo), 64'(vecs[i].exp_vo));
      if (vecs[i].chk_d) begin
        checkOutput($sformatf("vec%0d data_o", i), dout[vecs[i].chk_id], vecs[i].exp_d);
      end
    end

    // Entry pushed into an empty FIFO appears next cycle and holds while stalled.
    doReset();
    applyStimulus(1'b1, 2'd2, 64'hA5, 4'b0000);
    tick();
    applyStimulus(1'b0, 2'd0, 64'h0, 4'b0000);
    for (int c = 0; c < 5; c++) begin
      checkOutput($sformatf("hold%0d valid_o", c), 64'(vo), 64'h4);
      checkOutput($sformatf("hold%0d data_o[2]", c), dout[2], 64'hA5);
      tick();
    end

    // Full FIFO: third push waits until the cycle after the first pop.
    doReset();
    applyStimulus(1'b1, 2'd1, 64'd1, 4'b0000);
    checkOutput("full push1 ready_o", 64'(ro), 64'h1);
    tick();
    applyStimulus(1'b1, 2'd1, 64'd2, 4'b0000);
    checkOutput("full push2 ready_o", 64'(ro), 64'h1);
    tick();
    applyStimulus(1'b1, 2'd1, 64'd3, 4'b0000);
    checkOutput("full push3 ready_o", 64'(ro), 64'h0);
    tick();
    applyStimulus(1'b1, 2'd1, 64'd3, 4'b0010);
    checkOutput("full pop1 ready_o", 64'(ro), 64'h0);
    checkOutput("full order1", dout[1], 64'd1);
    tick();
    checkOutput("full after pop ready_o", 64'(ro), 64'h1);
    checkOutput("full order2", dout[1], 64'd2);
    tick();
    applyStimulus(1'b0, 2'd0, 64'h0, 4'b0010);
    checkOutput("full valid_o[1]", 64'(vo[1]), 64'h1);
    checkOutput("full order3", dout[1], 64'd3);
    tick();
    checkOutput("full drained valid_o", 64'(vo), 64'h0);

    // Simultaneous push and pop on a one-entry FIFO keeps occupancy at one.
    doReset();
    applyStimulus(1'b1, 2'd0, 64'h10, 4'b0000);
    tick();
    checkOutput("pushpop pre valid_o", 64'(vo), 64'h1);
    applyStimulus(1'b1, 2'd0, 64'h20, 4'b0001);
    checkOutput("pushpop ready_o", 64'(ro), 64'h1);
    tick();
    checkOutput("pushpop valid_o", 64'(vo), 64'h1);
    checkOutput("pushpop head", dout[0], 64'h20);
    applyStimulus(1'b0, 2'd0, 64'h0, 4'b0001);
    tick();
    checkOutput("pushpop single entry", 64'(vo), 64'h0);

    // Out-of-range IDs on the 3-destination instance are dropped and counted.
    doReset();
    v3 = 1'b1; id3 = 2'd3; d3 = 8'h5A;
    #1;
    checkOutput("oob ready_o", 64'(ro3), 64'h1);
    tick();
    checkOutput("oob valid_o", 64'(vo3), 64'h0);
    checkOutput("oob err_o", 64'(err3), 64'h1);
    checkOutput("oob err_cnt_o", 64'(err_cnt3), 64'h1);
    checkOutput("oob other dut err_o", 64'(err), 64'h0);
    v3 = 1'b0;
    tick();
    checkOutput("oob idle err_cnt_o", 64'(err_cnt3), 64'h1);
    v3 = 1'b1;
    repeat (253) tick();
    checkOutput("oob err_cnt_o 254", 64'(err_cnt3), 64'd254);
    repeat (46) tick();
    checkOutput("oob err_cnt_o sat", 64'(err_cnt3), 64'd255);
    checkOutput("oob sticky err_o", 64'(err3), 64'h1);
    checkOutput("oob final valid_o", 64'(vo3), 64'h0);
    id3 = 2'd1; d3 = 8'h3C;
    tick();
    v3 = 1'b0;
    checkOutput("dut3 route valid_o", 64'(vo3), 64'h2);
    checkOutput("dut3 route data_o[1]", 64'(dout3[1]), 64'h3C);

    // Reset asserted mid-cycle with every FIFO occupied.
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b1, 2'(i), 64'h100 + 64'(i), 4'b0000);
      tick();
    end
    applyStimulus(1'b0, 2'd0, 64'h0, 4'b0000);
    checkOutput("prereset valid_o", 64'(vo), 64'hF);
    #2;
    rst_n = 1'b0;
    #1;
    checkOutput("midreset valid_o", 64'(vo), 64'h0);
    checkOutput("midreset dut3 valid_o", 64'(vo3), 64'h0);
    checkOutput("midreset err_o", 64'(err3), 64'h0);
    checkOutput("midreset err_cnt_o", 64'(err_cnt3), 64'h0);
    tick();
    rst_n = 1'b1;
    for (int i = 0; i < N; i++) begin
      applyStimulus(1'b0, 2'(i), 64'h0, 4'b0000);
      checkOutput($sformatf("postreset ready_o id%0d", i), 64'(ro), 64'h1);
    end
    applyStimulus(1'b1, 2'd1, 64'h77, 4'b0000);
    tick();
    checkOutput("postreset valid_o", 64'(vo), 64'h2);
    checkOutput("postreset data_o[1]", dout[1], 64'h77);

    // Random traffic with a per-destination queue scoreboard.
    doReset();
    for (int c = 0; c < 2000; c++) begin
      randomStep(1'($urandom_range(0, 1)), 2'($urandom_range(0, 3)),
                 {$urandom, $urandom}, 4'($urandom_range(0, 15)));
    end
    for (int c = 0; c < 4; c++) begin
      randomStep(1'b0, 2'd0, 64'h0, 4'b1111);
    end
    checkOutput("rand drained valid_o", 64'(vo), 64'h0);

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
